vga_pixel_gen: RTL and testbench

- Downstream consumer of the 640x480 VGA sync generator. Takes its pixel_x, pixel_y, video_on, hsync, vsync and p_tick and produces the 12-bit RGB stream plus re-aligned sync outputs for the connector.
- Draws a fixed white frame border, a background fill, and one square box that bounces inside the border, advancing once per video frame.
- Pixel data is registered in two stages; the sync outputs are delayed by the same amount, so RGB and syncs stay aligned at the pins.

---
 rtl/vga_pixel_gen.sv | 152 +++++++++++++++
 tb/tb_vga_pixel_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_gen.sv
// Pixel colour generator for a 640x480 VGA stream: border, background fill and a
// square box that bounces once per frame; RGB and syncs leave through a 2-strobe pipe.
`timescale 1ns/1ps

module vga_axis_motion #(
  parameter int MIN  = 8,
  parameter int MAX  = 600,
  parameter int STEP = 2,
  parameter int INIT = 304
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] pos,
  output logic       bounce
);
  typedef enum logic {INC, DEC} dir_t;
  dir_t        dir;
  logic [10:0] pos_w, up;
  logic        hit_max, hit_min;

  // 11-bit compares keep pos+STEP and MIN+STEP free of wrap-around
  assign pos_w   = {1'b0, pos};
  assign up      = pos_w + 11'(STEP);
  assign hit_max = up >= 11'(MAX);
  assign hit_min = pos_w <= 11'(MIN + STEP);
  assign bounce  = en & ((dir == INC) ? hit_max : hit_min);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos <= 10'(INIT);
      dir <= INC;
    end else if (en) begin
      case (dir)
        INC: if (hit_max) begin pos <= 10'(MAX); dir <= DEC; end
             else pos <= up[9:0];
        DEC: if (hit_min) begin pos <= 10'(MIN); dir <= INC; end
             else pos <= pos - 10'(STEP);
      endcase
    end
  end
endmodule

module vga_pixel_gen #(
  parameter int          BOX_SIZE     = 32,
  parameter int          STEP         = 2,
  parameter int          BORDER_W     = 8,
  parameter logic [11:0] BG_COLOR     = 12'h008,
  parameter logic [11:0] BORDER_COLOR = 12'hFFF
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        pause,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_tick
);
  localparam int XMAX = 640 - BORDER_W - BOX_SIZE;
  localparam int YMAX = 480 - BORDER_W - BOX_SIZE;
  localparam logic [3:0][11:0] PAL = {12'hFF0, 12'h00F, 12'h0F0, 12'hF00};

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
  } pix_t;

  logic             p_tick_d, vsync_d, ps, move_en;
  pix_t             s1;
  logic [1:0]       color_idx;
  logic [1:0][9:0]  box_pos;
  logic [1:0]       bounce;
  logic [10:0]      x_w, y_w, bx_w, by_w;
  logic             in_border, in_box;
  logic [11:0]      pix_color;

  assign ps         = p_tick_d & ~p_tick;
  assign frame_tick = vsync_d & ~vsync;
  assign move_en    = frame_tick & ~pause;

  // axis 0 = x, axis 1 = y; positions only move on the vsync falling edge
  for (genvar a = 0; a < 2; a++) begin : g_axis
    vga_axis_motion #(
      .MIN (BORDER_W),
      .MAX ((a == 0) ? XMAX : YMAX),
      .STEP(STEP),
      .INIT((a == 0) ? 304 : 224)
    ) u_axis (
      .clk   (clk),
      .reset (reset),
      .en    (move_en),
      .pos   (box_pos[a]),
      .bounce(bounce[a])
    );
  end

  assign x_w  = {1'b0, s1.x};
  assign y_w  = {1'b0, s1.y};
  assign bx_w = {1'b0, box_pos[0]};
  assign by_w = {1'b0, box_pos[1]};

  assign in_border = (x_w < 11'(BORDER_W)) || (x_w >= 11'(640 - BORDER_W)) ||
                     (y_w < 11'(BORDER_W)) || (y_w >= 11'(480 - BORDER_W));
  assign in_box    = (x_w >= bx_w) && (x_w < bx_w + 11'(BOX_SIZE)) &&
                     (y_w >= by_w) && (y_w < by_w + 11'(BOX_SIZE));

  always_comb begin
    pix_color = BG_COLOR;
    if (!s1.von)        pix_color = '0;
    else if (in_border) pix_color = BORDER_COLOR;
    else if (in_box)    pix_color = PAL[color_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_tick_d <= 1'b0;
      vsync_d  <= 1'b0;
    end else begin
      p_tick_d <= p_tick;
      vsync_d  <= vsync;
    end
  end

  // corner hits raise both bounce bits but advance the palette only once
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          color_idx <= 2'd0;
    else if (|bounce)   color_idx <= color_idx + 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1        <= '{x: 10'd0, y: 10'd0, von: 1'b0, hs: 1'b1, vs: 1'b1};
      rgb       <= 12'h000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else if (ps) begin
      s1        <= '{x: pixel_x, y: pixel_y, von: video_on, hs: hsync, vs: vsync};
      rgb       <= pix_color;
      hsync_out <= s1.hs;
      vsync_out <= s1.vs;
    end
  end
endmodule

// File: tb/tb_vga_pixel_gen.sv
// Randomized bench for vga_pixel_gen against a frame-level model of box motion and colour rules.
`timescale 1ns/1ps

module tb_vga_pixel_gen;
  logic        clk = 1'b0;
  logic        reset, p_tick, video_on, hsync, vsync, pause;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, frame_tick;

  always #5 clk = ~clk;

  vga_pixel_gen dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .hsync(hsync), .vsync(vsync), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pause(pause), .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .frame_tick(frame_tick)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: box position, signed direction, palette index, history of strobed pixels
  typedef struct { int x; int y; bit von; bit hs; bit vs; } mpix_t;
  int          bx, by, dx, dy, cidx;
  bit          vs_cur;
  mpix_t       hist[$];
  logic [11:0] pal [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0};

  function automatic logic [11:0] colour(input mpix_t p);
    if (!p.von) return 12'h000;
    if (p.x < 8 || p.x >= 632 || p.y < 8 || p.y >= 472) return 12'hFFF;
    if (p.x >= bx && p.x < bx + 32 && p.y >= by && p.y < by + 32) return pal[cidx];
    return 12'h008;
  endfunction

  task automatic mreset();
    bx = 304; by = 224; dx = 1; dy = 1; cidx = 0;
    hist = {};
    hist.push_back('{x: 0, y: 0, von: 0, hs: 1, vs: 1});
  endtask

  task automatic move(inout int p, inout int d, input int hi, output bit b);
    int n;
    n = p + 2 * d;
    b = 0;
    if (d > 0 && n >= hi)     begin p = hi; d = -1; b = 1; end
    else if (d < 0 && n <= 8) begin p = 8;  d = 1;  b = 1; end
    else p = n;
  endtask

  task automatic mstep();
    bit b1, b2;
    if (pause) return;
    move(bx, dx, 600, b1);
    move(by, dy, 440, b2);
    if (b1 || b2) cidx = (cidx + 1) % 4;
  endtask

  // one full p_tick period; the strobe lands on the falling edge of p_tick
  task automatic pix(input int x, input int y, input bit von, input bit hs, input bit vs);
    mpix_t e;
    @(negedge clk);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = von; hsync = hs; vsync = vs;
    p_tick = 1'b1;
    if (vs_cur && !vs) mstep();
    vs_cur = vs;
    @(negedge clk); @(negedge clk);
    p_tick = 1'b0;
    @(negedge clk);
    hist.push_back('{x: x, y: y, von: von, hs: hs, vs: vs});
    e = hist[hist.size() - 2];
    chk("rgb", rgb, colour(e));
    chk("hsync_out", hsync_out, e.hs);
    chk("vsync_out", vsync_out, e.vs);
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  task automatic frame();
    @(negedge clk);
    vsync = 1'b0; vs_cur = 0;
    #1 chk("ftick_hi", frame_tick, 1);
    mstep();
    @(negedge clk);
    #1 chk("ftick_lo", frame_tick, 0);
    vsync = 1'b1; vs_cur = 1;
  endtask

  task automatic probe();
    pix(bx + 16, by + 16, 1, 1, 1);
    pix(bx - 1, by, 1, 1, 1);
    pix(bx + 31, by + 31, 1, 1, 1);
    pix(bx + 32, by + 5, 1, 1, 1);
    pix(bx + 5, by + 32, 1, 1, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1; p_tick = 0; video_on = 0; hsync = 1; vsync = 1; pause = 0;
    pixel_x = '0; pixel_y = '0; vs_cur = 1;
    mreset();
    repeat (3) @(negedge clk);
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_hso", hsync_out, 1);
    chk("rst_vso", vsync_out, 1);
    chk("rst_ftick", frame_tick, 0);
    reset = 0;

    // directed colours, each visible two strobes after it is driven
    pix(320, 240, 1, 1, 1);
    pix(100, 100, 1, 1, 1);  chk("box_f00", rgb, 12'hF00);
    pix(3, 100, 1, 1, 1);    chk("bg_008", rgb, 12'h008);
    pix(700, 100, 0, 1, 1);  chk("border_fff", rgb, 12'hFFF);
    pix(10, 10, 1, 1, 1);    chk("blank_000", rgb, 12'h000);

    // hsync latency and alignment with rgb
    pix(200, 200, 1, 0, 1);  chk("hs_lat1", hsync_out, 1);
    pix(201, 200, 1, 1, 1);  chk("hs_lat2", hsync_out, 0); chk("hs_rgb", rgb, 12'h008);
    pix(202, 200, 1, 1, 1);  chk("hs_lat3", hsync_out, 1);

    repeat (200)
      pix($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom), 1'($urandom), 1);

    // mid-line reset
    pix(3, 3, 1, 1, 1);
    pix(4, 4, 1, 1, 1);
    @(negedge clk);
    reset = 1; vsync = 0;
    #1;
    chk("mid_rst_rgb", rgb, 12'h000);
    chk("mid_rst_hso", hsync_out, 1);
    chk("mid_rst_vso", vsync_out, 1);
    chk("mid_rst_ftick", frame_tick, 0);
    repeat (3) @(negedge clk);
    vsync = 1; reset = 0; vs_cur = 1;
    mreset();
    pix(320, 240, 1, 1, 1);
    pix(304, 224, 1, 1, 1);  chk("first_box", rgb, 12'hF00);
    pix(335, 255, 1, 1, 1);  chk("first_box_tl", rgb, 12'hF00);
    pix(336, 255, 1, 1, 1);  chk("first_box_br", rgb, 12'hF00);
    pix(100, 100, 1, 1, 1);  chk("first_box_out", rgb, 12'h008);

    // long run covers x bounce (148), y bounce (108) and the corner hit (3996)
    for (int f = 1; f <= 4100; f++) begin
      frame();
      if (f inside {107, 108, 109, 147, 148, 149, 444, 3995, 3996, 3997} || f % 41 == 0)
        probe();
      if (f == 3996) chk("corner_cidx_probe", colour('{x: bx + 16, y: by + 16, von: 1, hs: 1, vs: 1}), pal[cidx]);
    end

    // pause: ticks still pulse, box stays frozen
    pause = 1;
    for (int i = 0; i < 5; i++) begin
      frame();
      probe();
    end
    pause = 0;
    frame();
    probe();
    repeat (60)
      pix($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom), 1'($urandom), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
